// File: rtl/compare_if.sv
// Handshake bundle for compare_pipe: operand-side valid/ready, result-side
// valid/ready, flush control and the result/status fields.
interface compare_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic [2:0]       cond;
    logic [TAG_W-1:0] tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             taken;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      taken_count;

    // Producer/consumer side that feeds operands and accepts results.
    modport master (
        output in_valid, a, b, is_signed, cond, tag, flush, out_ready,
        input  in_ready, out_valid, gt, lt, eq, taken, out_tag, taken_count
    );

    // The compare pipeline itself.
    modport slave (
        input  in_valid, a, b, is_signed, cond, tag, flush, out_ready,
        output in_ready, out_valid, gt, lt, eq, taken, out_tag, taken_count
    );
endinterface

// File: rtl/compare_pipe.sv
// Two-stage signed/unsigned magnitude comparator with condition evaluation,
// valid/ready flow control on both sides, flush, and a saturating counter of
// consumed results whose condition was true.
module compare_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    compare_if.slave bus
);
    localparam logic [2:0]  C_EQ     = 3'b000;
    localparam logic [2:0]  C_NE     = 3'b001;
    localparam logic [2:0]  C_LT     = 3'b010;
    localparam logic [2:0]  C_GE     = 3'b011;
    localparam logic [2:0]  C_GT     = 3'b100;
    localparam logic [2:0]  C_LE     = 3'b101;
    localparam logic [2:0]  C_ALWAYS = 3'b110;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // One extra bit lets both signednesses share a single signed comparator:
    // sign-extend for two's complement, zero-extend for unsigned.
    function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                                     input logic sgn);
        logic signed [WIDTH:0] e;
        e = sgn ? {v[WIDTH-1], v} : {1'b0, v};
        return e;
    endfunction

    // Returns {gt, lt, eq}; exactly one bit is set.
    function automatic logic [2:0] relation(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic sgn);
        logic signed [WIDTH:0] ex;
        logic signed [WIDTH:0] ey;
        ex = extend(x, sgn);
        ey = extend(y, sgn);
        return {ex > ey, ex < ey, ex == ey};
    endfunction

    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] r);
        logic t;
        case (c)
            C_EQ:     t = r[0];
            C_NE:     t = !r[0];
            C_LT:     t = r[1];
            C_GE:     t = r[2] | r[0];
            C_GT:     t = r[2];
            C_LE:     t = r[1] | r[0];
            C_ALWAYS: t = 1'b1;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == CNT_MAX) ? c : c + 16'd1;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             sgn_p1;
    logic [2:0]       cond_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             vld_p2;
    logic             gt_p2;
    logic             lt_p2;
    logic             eq_p2;
    logic             taken_p2;
    logic [TAG_W-1:0] tag_p2;

    logic [15:0]      cnt;

    logic             s2_free;
    logic             in_rdy;
    logic             acc;
    logic             adv;
    logic             out_hs;
    logic [2:0]       rel_p1;

    // in_ready deliberately ignores in_valid so producers may wait on it.
    assign s2_free = !vld_p2 || bus.out_ready;
    assign in_rdy  = reset && !bus.flush && (!vld_p1 || s2_free);
    assign acc     = bus.in_valid && in_rdy;
    assign adv     = vld_p1 && s2_free;
    assign out_hs  = vld_p2 && bus.out_ready;
    assign rel_p1  = relation(a_p1, b_p1, sgn_p1);

    // Stage occupancy: reset beats flush, flush beats any fill or drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (acc)
                vld_p1 <= 1'b1;
            else if (adv)
                vld_p1 <= 1'b0;
            if (adv)
                vld_p2 <= 1'b1;
            else if (out_hs)
                vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (acc) begin
            a_p1    <= bus.a;
            b_p1    <= bus.b;
            sgn_p1  <= bus.is_signed;
            cond_p1 <= bus.cond;
            tag_p1  <= bus.tag;
        end
    end

    // ---- stage 2: compare result, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            gt_p2    <= 1'b0;
            lt_p2    <= 1'b0;
            eq_p2    <= 1'b0;
            taken_p2 <= 1'b0;
            tag_p2   <= '0;
        end else if (adv) begin
            gt_p2    <= rel_p1[2];
            lt_p2    <= rel_p1[1];
            eq_p2    <= rel_p1[0];
            taken_p2 <= cond_true(cond_p1, rel_p1);
            tag_p2   <= tag_p1;
        end
    end

    // Count consumed taken results; a handshake coinciding with flush still counts.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (out_hs && taken_p2)
            cnt <= sat_inc(cnt);
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = vld_p2;
    assign bus.gt          = gt_p2;
    assign bus.lt          = lt_p2;
    assign bus.eq          = eq_p2;
    assign bus.taken       = taken_p2;
    assign bus.out_tag     = tag_p2;
    assign bus.taken_count = cnt;
endmodule

// File: tb/tb_compare_pipe.sv
// Self-checking bench for compare_pipe: directed vectors, streaming,
// backpressure, flush, randomized traffic against a queue model, and
// counter saturation / reset.
module tb_compare_pipe;
    localparam int W = 16;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;

    compare_if #(.WIDTH(W), .TAG_W(T)) bus ();

    compare_pipe #(.WIDTH(W), .TAG_W(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct packed {
        logic         gt;
        logic         lt;
        logic         eq;
        logic         taken;
        logic [T-1:0] tag;
    } res_t;

    res_t q[$];
    int   tc;
    int   checks   = 0;
    int   failures = 0;

    // Reference: numeric values of the operands, then plain comparisons.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic [2:0] c,
                                   input logic [T-1:0] t);
        res_t   r;
        longint va;
        longint vb;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[W-1]) va = va - (longint'(1) << W);
        if (s && b[W-1]) vb = vb - (longint'(1) << W);
        r.gt  = (va > vb);
        r.lt  = (va < vb);
        r.eq  = (va == vb);
        r.tag = t;
        case (c)
            3'd0: r.taken = (va == vb);
            3'd1: r.taken = (va != vb);
            3'd2: r.taken = (va < vb);
            3'd3: r.taken = (va >= vb);
            3'd4: r.taken = (va > vb);
            3'd5: r.taken = (va <= vb);
            3'd6: r.taken = 1'b1;
            default: r.taken = 1'b0;
        endcase
        return r;
    endfunction

    function automatic res_t cur();
        return {bus.gt, bus.lt, bus.eq, bus.taken, bus.out_tag};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2:0] c, input logic [T-1:0] t);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        bus.cond      = c;
        bus.tag       = t;
    endtask

    // Advance one clock: update the model from the handshakes about to occur.
    task automatic tick();
        logic acc;
        logic hs;
        acc = bus.in_valid && bus.in_ready;
        hs  = bus.out_valid && bus.out_ready;
        if (!reset) begin
            q.delete();
            tc = 0;
        end else begin
            if (hs && q.size() > 0) begin
                if (q[0].taken && tc < 65535) tc++;
                void'(q.pop_front());
            end
            if (bus.flush)
                q.delete();
            else if (acc)
                q.push_back(model(bus.a, bus.b, bus.is_signed, bus.cond, bus.tag));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h0042, 1'b0, 3'd6, 4'h5);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.gt, bus.lt, bus.eq, bus.taken} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.gt, bus.lt, bus.eq, bus.taken}); end
        checks++; if (bus.out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); end
        checks++; if (bus.taken_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.taken_count); end
        tick();
        reset = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic         vs [5];
        logic [2:0]   vc [5];
        logic [3:0]   ve [5];
        va = '{16'hFFF6, 16'hFFF6, 16'h8000, 16'h8000, 16'h7FFF};
        vb = '{16'h000A, 16'h000A, 16'h8000, 16'h8000, 16'h8000};
        vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vc = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd4};
        ve = '{4'b0101, 4'b1000, 4'b0011, 4'b0011, 4'b1001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, va[i], vb[i], vs[i], vc[i], T'(i));
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            #1;
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_early_valid got=%b exp=0", i, bus.out_valid); end
            tick();
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_latency got=%b exp=1", i, bus.out_valid); end
            checks++; if ({bus.gt, bus.lt, bus.eq, bus.taken} !== ve[i]) begin failures++; $display("FAIL vec%0d_flags gt/lt/eq/taken got=%b exp=%b", i, {bus.gt, bus.lt, bus.eq, bus.taken}, ve[i]); end
            checks++; if (bus.out_tag !== T'(i)) begin failures++; $display("FAIL vec%0d_tag got=%h exp=%h", i, bus.out_tag, T'(i)); end
            tick();
        end
        #1;
        checks++; if (bus.taken_count !== 16'd4) begin failures++; $display("FAIL vec_count got=%0d exp=4", bus.taken_count); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcv = 0;
        int first = -1;
        int last = -1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (sent < 8)
                drive(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), T'(sent));
            else
                bus.in_valid = 1'b0;
            #1;
            if (bus.in_valid) begin
                checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready); end
                if (bus.in_ready) sent++;
            end
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || cur() !== q[0] || bus.out_tag !== T'(rcv)) begin
                    failures++; $display("FAIL b2b_result cyc=%0d got=%h exp_tag=%0d", cyc, cur(), rcv);
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            tick();
        end
        checks++; if (rcv != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rcv); end
        checks++; if (first != 2) begin failures++; $display("FAIL b2b_latency first_out_cycle got=%0d exp=2", first); end
        checks++; if (last - first != 7) begin failures++; $display("FAIL b2b_consecutive span got=%0d exp=7", last - first); end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   rcv = 0;
        int   drops = 0;
        logic prev_stall = 1'b0;
        res_t prev;
        prev = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc < 8);
            if (sent < 8)
                drive(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), T'(sent));
            else
                bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.in_ready !== (q.size() < 2 || bus.out_ready)) begin
                failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, (q.size() < 2 || bus.out_ready));
            end
            if (bus.in_valid && !bus.in_ready) drops++;
            if (bus.in_valid && bus.in_ready) sent++;
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || cur() !== prev) begin
                    failures++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, cur(), prev);
                end
            end
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || cur() !== q[0] || bus.out_tag !== T'(rcv)) begin
                    failures++; $display("FAIL bp_result cyc=%0d got=%h exp_tag=%0d", cyc, cur(), rcv);
                end
                if (bus.out_ready) rcv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = cur();
            tick();
        end
        checks++; if (drops == 0) begin failures++; $display("FAIL bp_ready_drop got=0 stalled_cycles exp>0"); end
        checks++; if (rcv != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rcv); end
    endtask

    task automatic test_flush();
        logic [15:0] cnt;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0002, 1'b0, 3'd6, 4'hA);
        #1; tick();
        drive(1'b1, 16'h0003, 16'h0003, 1'b0, 3'd6, 4'hB);
        #1; tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%b exp=1", bus.out_valid); end
        cnt = bus.taken_count;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard cyc=%0d got=%b exp=0 tag=%h", i, bus.out_valid, bus.out_tag); end
            tick();
        end
        #1;
        checks++; if (bus.taken_count !== cnt) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", bus.taken_count, cnt); end
        // Output handshake in the same cycle as flush still counts.
        drive(1'b1, 16'h0005, 16'h0006, 1'b1, 3'd6, 4'h3);
        tick();
        bus.in_valid = 1'b0;
        #1; tick();
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_hs_valid got=%b exp=1", bus.out_valid); end
        cnt = bus.taken_count;
        bus.flush = 1'b1;
        #1; tick();
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.taken_count !== cnt + 16'd1) begin failures++; $display("FAIL flush_hs_count got=%0d exp=%0d", bus.taken_count, cnt + 16'd1); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_hs_after got=%b exp=0", bus.out_valid); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        res_t prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        prev = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0, 1: rb = ra;
                2: begin ra = 16'h8000; rb = 16'h7FFF; end
                3: begin ra = 16'hFFFF; rb = 16'h0000; end
                default: ;
            endcase
            drive(1'($urandom_range(0, 9) < 7), ra, rb, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), T'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush = ($urandom_range(0, 99) < 4);
            #1;
            checks++;
            if (bus.in_ready !== (!bus.flush && (q.size() < 2 || bus.out_ready))) begin
                failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b pending=%0d", cyc, bus.in_ready, q.size());
            end
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || cur() !== q[0]) begin
                    failures++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, cur(), (q.size() > 0) ? q[0] : res_t'(0));
                end
                checks++;
                if ($countones({bus.gt, bus.lt, bus.eq}) != 1) begin
                    failures++; $display("FAIL rnd_onehot cyc=%0d got=%b", cyc, {bus.gt, bus.lt, bus.eq});
                end
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || cur() !== prev) begin
                    failures++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, cur(), prev);
                end
            end
            checks++;
            if (bus.taken_count !== 16'(tc)) begin
                failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.taken_count, tc);
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
            prev = cur();
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin #1; tick(); end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_drain undelivered=%0d exp=0", q.size()); end
    endtask

    task automatic test_saturation();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 3'd6, 4'h7);
        for (int n = 0; n < 65540; n++) tick();
        #1;
        checks++; if (bus.taken_count !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", bus.taken_count); end
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL sat_reset_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.taken_count !== 16'h0) begin failures++; $display("FAIL sat_reset_count got=%h exp=0", bus.taken_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sat_reset_discard cyc=%0d got=%b exp=0", i, bus.out_valid); end
            tick();
            #1;
        end
    endtask

    // Watchdog: the scenarios are bounded, this only guards against a stuck clock.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Scenario sequence and summary.
    initial begin
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 3'd0, '0);
        tc = 0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
